// File: rtl/uzorak_sakupljac_if.sv
// Sample-assembler port bundle: serial feature stream in, assembled sample out.
// Latency: none (wires only).
// Backpressure: in_ready gates the feature stream, uzorak_prihvacen releases the held sample.
//
// Signals:
//   in_podatak/in_valid/in_sof/in_ready : serial 16-bit feature stream, SOF marks feature 0
//   uzorak/uzorak_valid/uzorak_prihvacen : assembled sample held until acknowledged
//   greska_okvira                        : one-cycle framing error pulse
// Modports: master = stream source / sample consumer, slave = the assembler.
interface uzorak_sakupljac_if #(
  parameter int BROJ_ZNACAJKI = 60,
  parameter int SIRINA        = 16
);
  logic [SIRINA-1:0]               in_podatak;
  logic                            in_valid;
  logic                            in_sof;
  logic                            in_ready;
  logic [BROJ_ZNACAJKI*SIRINA-1:0] uzorak;
  logic                            uzorak_valid;
  logic                            uzorak_prihvacen;
  logic                            greska_okvira;

  modport master (
    output in_podatak, in_valid, in_sof, uzorak_prihvacen,
    input  in_ready, uzorak, uzorak_valid, greska_okvira
  );

  modport slave (
    input  in_podatak, in_valid, in_sof, uzorak_prihvacen,
    output in_ready, uzorak, uzorak_valid, greska_okvira
  );
endinterface

// File: rtl/uzorak_sakupljac.sv
// Assembles 60 serial 16-bit features into one 960-bit sample held for the neuron array.
// Latency: 1 cycle registered from the final accepted beat to uzorak/uzorak_valid.
// Backpressure: in_ready drops only when a full fill buffer waits on an unacknowledged sample.
//
// Ports: clk, rst_n (async, active low); io (slave modport) carries the feature stream,
// the assembled sample with its valid/ack pair, and the framing error pulse.
module uzorak_sakupljac #(
  parameter int BROJ_ZNACAJKI = 60,
  parameter int SIRINA        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  uzorak_sakupljac_if.slave   io
);

  localparam int                UZ_W   = BROJ_ZNACAJKI * SIRINA;
  localparam int                IDX_W  = $clog2(BROJ_ZNACAJKI);
  localparam logic [IDX_W-1:0]  ZADNJI = IDX_W'(BROJ_ZNACAJKI - 1);

  typedef enum logic {
    PUNJENJE = 1'b0,  // fill buffer accepting beats
    PUN      = 1'b1   // fill buffer complete, waiting for the output register
  } stanje_t;

  stanje_t           stanje_q, stanje_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SIRINA-1:0] buf_q [BROJ_ZNACAJKI];
  logic [SIRINA-1:0] buf_d [BROJ_ZNACAJKI];
  logic [UZ_W-1:0]   uzorak_q, uzorak_d;
  logic              uzorak_valid_q, uzorak_valid_d;
  logic              greska_q, greska_d;

  logic              prihvat;
  logic              izlaz_slobodan;
  logic              prijenos;

  // in_ready depends on state only, so a release out of PUN shows up one cycle after the ack.
  assign io.in_ready    = (stanje_q == PUNJENJE);
  assign prihvat        = io.in_valid && (stanje_q == PUNJENJE);
  // The output register counts as free in the very cycle it is being acknowledged.
  assign izlaz_slobodan = !uzorak_valid_q || io.uzorak_prihvacen;

  always_comb begin
    stanje_d       = stanje_q;
    idx_d          = idx_q;
    buf_d          = buf_q;
    uzorak_d       = uzorak_q;
    greska_d       = 1'b0;
    prijenos       = 1'b0;
    // An ack clears valid unless a transfer below re-asserts it on the same edge.
    uzorak_valid_d = uzorak_valid_q && !io.uzorak_prihvacen;

    case (stanje_q)
      PUNJENJE: begin
        if (prihvat) begin
          if (io.in_sof) begin
            // SOF always restarts the frame; it is an error only if a partial frame is dropped.
            buf_d[0] = io.in_podatak;
            idx_d    = IDX_W'(1);
            greska_d = (idx_q != '0);
          end else if (idx_q == '0) begin
            greska_d = 1'b1;  // orphan beat, dropped
          end else begin
            buf_d[idx_q] = io.in_podatak;
            if (idx_q == ZADNJI) begin
              if (izlaz_slobodan) begin
                prijenos = 1'b1;
                idx_d    = '0;
              end else begin
                stanje_d = PUN;
              end
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end
      PUN: begin
        if (izlaz_slobodan) begin
          prijenos = 1'b1;
          idx_d    = '0;
          stanje_d = PUNJENJE;
        end
      end
      default: stanje_d = PUNJENJE;
    endcase

    // Copy from buf_d so the completing beat lands in the sample on the same edge.
    if (prijenos) begin
      uzorak_valid_d = 1'b1;
      for (int k = 0; k < BROJ_ZNACAJKI; k++) begin
        uzorak_d[k*SIRINA +: SIRINA] = buf_d[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stanje_q       <= PUNJENJE;
      idx_q          <= '0;
      uzorak_q       <= '0;
      uzorak_valid_q <= 1'b0;
      greska_q       <= 1'b0;
      for (int k = 0; k < BROJ_ZNACAJKI; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      stanje_q       <= stanje_d;
      idx_q          <= idx_d;
      uzorak_q       <= uzorak_d;
      uzorak_valid_q <= uzorak_valid_d;
      greska_q       <= greska_d;
      for (int k = 0; k < BROJ_ZNACAJKI; k++) begin
        buf_q[k] <= buf_d[k];
      end
    end
  end

  assign io.uzorak        = uzorak_q;
  assign io.uzorak_valid  = uzorak_valid_q;
  assign io.greska_okvira = greska_q;

endmodule

// File: tb/tb_uzorak_sakupljac.sv
// Directed bench for uzorak_sakupljac: framing table plus multi-cycle frame sequences.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: beats are held until in_ready, with a bounded wait.
module tb_uzorak_sakupljac;

  logic clk;
  logic rst_n;

  uzorak_sakupljac_if #(.BROJ_ZNACAJKI(60), .SIRINA(16)) io ();

  uzorak_sakupljac #(.BROJ_ZNACAJKI(60), .SIRINA(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec   = 0;
  int n_bad   = 0;
  int err_cnt = 0;
  int low_cnt = 0;

  typedef struct {
    logic        vld;
    logic        sof;
    logic [15:0] dat;
    logic        ack;
    logic        exp_rdy;
    logic        exp_uv;
    logic        exp_err;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [959:0] okvir(input logic [15:0] baza);
    logic [959:0] r;
    for (int k = 0; k < 60; k++) r[k*16 +: 16] = baza + 16'(k);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (io.greska_okvira) err_cnt++;
    if (!io.uzorak_valid) low_cnt++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_u(input string nm, input logic [959:0] exp);
    n_vec++;
    if (io.uzorak !== exp) begin
      n_bad++;
      for (int k = 0; k < 60; k++) begin
        if (io.uzorak[k*16 +: 16] !== exp[k*16 +: 16]) begin
          $display("FAIL %s: slot %0d got %h, expected %h", nm, k,
                   io.uzorak[k*16 +: 16], exp[k*16 +: 16]);
          break;
        end
      end
    end
  endtask

  task automatic send_beat(input logic [15:0] d, input logic s, input logic a);
    int w;
    w = 0;
    io.in_valid         = 1'b1;
    io.in_sof           = s;
    io.in_podatak       = d;
    io.uzorak_prihvacen = a;
    while (!io.in_ready && w < 300) begin
      tick();
      w++;
    end
    if (!io.in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL beat_wait: in_ready stuck at 0, expected 1 within 300 cycles");
    end
    tick();
    io.uzorak_prihvacen = 1'b0;
  endtask

  task automatic idle();
    io.in_valid = 1'b0;
    io.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] baza, input logic ack_last);
    send_beat(baza, 1'b1, 1'b0);
    for (int k = 1; k < 59; k++) send_beat(baza + 16'(k), 1'b0, 1'b0);
    send_beat(baza + 16'd59, 1'b0, ack_last);
  endtask

  task automatic ack_once();
    io.uzorak_prihvacen = 1'b1;
    tick();
    io.uzorak_prihvacen = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [959:0] exp_u;

    // ---- framing table: ack while invalid, orphan beats, then SOF
    tbl[0] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'hDEA0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 16'hDEA1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 16'hDEA2, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 16'h0600, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_n               = 1'b1;
    io.in_valid         = 1'b0;
    io.in_sof           = 1'b0;
    io.in_podatak       = '0;
    io.uzorak_prihvacen = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", 32'(io.in_ready), 1);
    chk("rst_uzorak_valid", 32'(io.uzorak_valid), 0);
    chk("rst_greska", 32'(io.greska_okvira), 0);
    chk_u("rst_uzorak", '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(io.in_ready), 1);

    // ---- single frame 1..60, ack three cycles into valid
    err_cnt = 0;
    send_beat(16'd1, 1'b1, 1'b0);
    for (int k = 1; k < 59; k++) send_beat(16'(k + 1), 1'b0, 1'b0);
    chk("single_valid_before_last", 32'(io.uzorak_valid), 0);
    send_beat(16'd60, 1'b0, 1'b0);
    idle();
    chk("single_valid_rise", 32'(io.uzorak_valid), 1);
    chk_u("single_data", okvir(16'd1));
    tick();
    tick();
    chk("single_valid_held", 32'(io.uzorak_valid), 1);
    ack_once();
    chk("single_valid_fall", 32'(io.uzorak_valid), 0);
    chk_u("single_data_kept", okvir(16'd1));
    chk("single_no_err", 32'(err_cnt), 0);

    // ---- backpressure: A then B back-to-back, no ack
    send_frame(16'h1000, 1'b0);
    chk("bp_A_valid", 32'(io.uzorak_valid), 1);
    chk("bp_ready_after_A", 32'(io.in_ready), 1);
    send_frame(16'h2000, 1'b0);
    idle();
    chk("bp_ready_drop", 32'(io.in_ready), 0);
    chk_u("bp_hold_A", okvir(16'h1000));
    tick();
    tick();
    chk("bp_ready_still_low", 32'(io.in_ready), 0);
    chk_u("bp_still_A", okvir(16'h1000));
    ack_once();
    chk_u("bp_now_B", okvir(16'h2000));
    chk("bp_valid_kept", 32'(io.uzorak_valid), 1);
    chk("bp_ready_reopen", 32'(io.in_ready), 1);
    ack_once();
    chk("bp_valid_clear", 32'(io.uzorak_valid), 0);

    // ---- mid-frame SOF on beat 31
    err_cnt = 0;
    send_beat(16'h0301, 1'b1, 1'b0);
    for (int i = 2; i <= 30; i++) send_beat(16'h0300 + 16'(i), 1'b0, 1'b0);
    send_beat(16'h031F, 1'b1, 1'b0);
    chk("sof_err_pulse", 32'(io.greska_okvira), 1);
    send_beat(16'h0500, 1'b0, 1'b0);
    chk("sof_err_one_cycle", 32'(io.greska_okvira), 0);
    for (int j = 1; j <= 58; j++) send_beat(16'h0500 + 16'(j), 1'b0, 1'b0);
    idle();
    exp_u = '0;
    exp_u[15:0] = 16'h031F;
    for (int k = 1; k < 60; k++) exp_u[k*16 +: 16] = 16'h0500 + 16'(k - 1);
    chk("sof_valid", 32'(io.uzorak_valid), 1);
    chk_u("sof_data", exp_u);
    chk("sof_err_count", 32'(err_cnt), 1);
    ack_once();

    // ---- orphan beats via table, then complete the frame started in the table
    err_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      io.in_valid         = tbl[i].vld;
      io.in_sof           = tbl[i].sof;
      io.in_podatak       = tbl[i].dat;
      io.uzorak_prihvacen = tbl[i].ack;
      tick();
      chk($sformatf("tbl%0d_ready", i), 32'(io.in_ready), 32'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_uv", i), 32'(io.uzorak_valid), 32'(tbl[i].exp_uv));
      chk($sformatf("tbl%0d_err", i), 32'(io.greska_okvira), 32'(tbl[i].exp_err));
    end
    io.uzorak_prihvacen = 1'b0;
    for (int k = 1; k < 60; k++) send_beat(16'h0600 + 16'(k), 1'b0, 1'b0);
    idle();
    chk("orphan_err_count", 32'(err_cnt), 3);
    chk("orphan_valid", 32'(io.uzorak_valid), 1);
    chk_u("orphan_data", okvir(16'h0600));

    // ---- reset mid-frame while a sample is held
    err_cnt = 0;
    send_beat(16'h0700, 1'b1, 1'b0);
    for (int k = 1; k < 20; k++) send_beat(16'h0700 + 16'(k), 1'b0, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(io.uzorak_valid), 0);
    chk("mrst_ready", 32'(io.in_ready), 1);
    chk_u("mrst_uzorak", '0);
    tick();
    tick();
    chk("mrst_no_err", 32'(io.greska_okvira), 0);
    rst_n = 1'b1;
    tick();
    send_frame(16'h0800, 1'b0);
    idle();
    chk("mrst_next_valid", 32'(io.uzorak_valid), 1);
    chk_u("mrst_next_data", okvir(16'h0800));
    chk("mrst_err_count", 32'(err_cnt), 0);

    // ---- coincident ack and final beat of the next frame
    low_cnt = 0;
    send_beat(16'h0A00, 1'b1, 1'b0);
    for (int k = 1; k < 59; k++) send_beat(16'h0A00 + 16'(k), 1'b0, 1'b0);
    chk_u("coin_still_old", okvir(16'h0800));
    send_beat(16'h0A3B, 1'b0, 1'b1);
    idle();
    chk_u("coin_new_data", okvir(16'h0A00));
    chk("coin_valid", 32'(io.uzorak_valid), 1);
    chk("coin_no_low", 32'(low_cnt), 0);
    chk("coin_ready", 32'(io.in_ready), 1);
    ack_once();
    chk("coin_clear", 32'(io.uzorak_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
